// File: rtl/processing_element_v3.sv
// Multi-lane signed MAC with lane-wise or cross-lane reduction and a valid/ready group protocol.
// Define PE_SAT_EN to clip each lane result to 2*DATA_WIDTH bits and report clipping on ovf.
module processing_element_v3 #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_MACS   = 4,
  parameter int GUARD_BITS = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             acc_clr,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  input  logic [NUM_MACS*DATA_WIDTH-1:0]   a_flat,
  input  logic [NUM_MACS*DATA_WIDTH-1:0]   b_flat,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_MACS*2*DATA_WIDTH-1:0] mac_results_flat,
  output logic [CNT_WIDTH-1:0]             beat_count,
  output logic                             ovf
);

  localparam int RES_WIDTH = 2*DATA_WIDTH;
  localparam int ACC_WIDTH = RES_WIDTH+GUARD_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [ACC_WIDTH-1:0] acc     [NUM_MACS];
  logic signed [ACC_WIDTH-1:0] acc_nxt [NUM_MACS];
  logic signed [RES_WIDTH-1:0] prod    [NUM_MACS];
  logic signed [ACC_WIDTH-1:0] red_sum;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        mode_q;
  logic                        mode_eff;
  logic                        accept;
  logic                        deliver;

  assign in_ready  = rst && (state != DONE);
  assign out_valid = rst && (state == DONE);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  // The group's mode is taken from its first beat, later beats use the latched copy.
  assign mode_eff  = (state == IDLE) ? mode : mode_q;

  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NUM_MACS; i++) begin
      prod[i] = RES_WIDTH'($signed(a_flat[DATA_WIDTH*i +: DATA_WIDTH]))
              * RES_WIDTH'($signed(b_flat[DATA_WIDTH*i +: DATA_WIDTH]));
      red_sum = red_sum + ACC_WIDTH'(prod[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MACS; i++) begin
      acc_nxt[i] = acc[i];
    end
    if (accept) begin
      if (mode_eff) begin
        acc_nxt[0] = acc[0] + red_sum;
      end else begin
        for (int i = 0; i < NUM_MACS; i++) begin
          acc_nxt[i] = acc[i] + ACC_WIDTH'(prod[i]);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = in_last ? DONE : ACC;
      ACC:  if (accept && in_last) state_nxt = DONE;
      DONE: if (deliver) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (acc_clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || acc_clr) begin
      mode_q <= 1'b0;
    end else if (accept && state == IDLE) begin
      mode_q <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || acc_clr || deliver) begin
      for (int i = 0; i < NUM_MACS; i++) begin
        acc[i] <= '0;
      end
      cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_MACS; i++) begin
        acc[i] <= acc_nxt[i];
      end
      if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
    end
  end

`ifdef PE_SAT_EN
  logic ovf_q;
  logic ovf_nxt;

  function automatic logic clips(input logic signed [ACC_WIDTH-1:0] v);
    return !((&v[ACC_WIDTH-1:RES_WIDTH-1]) || !(|v[ACC_WIDTH-1:RES_WIDTH-1]));
  endfunction

  function automatic logic [RES_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    if (!clips(v)) return v[RES_WIDTH-1:0];
    else if (v[ACC_WIDTH-1]) return {1'b1, {(RES_WIDTH-1){1'b0}}};
    else return {1'b0, {(RES_WIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    ovf_nxt = 1'b0;
    for (int i = 0; i < NUM_MACS; i++) begin
      ovf_nxt = ovf_nxt | clips(acc_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || acc_clr || deliver) begin
      ovf_q <= 1'b0;
    end else if (accept && in_last) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign ovf = out_valid && ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    mac_results_flat = '0;
    if (out_valid) begin
      for (int i = 0; i < NUM_MACS; i++) begin
`ifdef PE_SAT_EN
        mac_results_flat[RES_WIDTH*i +: RES_WIDTH] = sat(acc[i]);
`else
        mac_results_flat[RES_WIDTH*i +: RES_WIDTH] = acc[i][RES_WIDTH-1:0];
`endif
      end
    end
  end

  assign beat_count = out_valid ? cnt : '0;

endmodule

// File: tb/tb_processing_element_v3.sv
// Directed bench for processing_element_v3: vector table plus reset, stall,
// abort, saturation and counter-limit sequences.
module tb_processing_element_v3;

  logic         clk = 1'b0;
  logic         rst;
  logic         acc_clr;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [63:0]  a_flat;
  logic [63:0]  b_flat;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mac_results_flat;
  logic [15:0]  beat_count;
  logic         ovf;

  int n_chk  = 0;
  int n_fail = 0;

  processing_element_v3 dut (
    .clk              (clk),
    .rst              (rst),
    .acc_clr          (acc_clr),
    .mode             (mode),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_last          (in_last),
    .a_flat           (a_flat),
    .b_flat           (b_flat),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .mac_results_flat (mac_results_flat),
    .beat_count       (beat_count),
    .ovf              (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         md;
    logic         iv;
    logic         il;
    logic         ordy;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         e_ir;
    logic         e_ov;
    logic [127:0] e_res;
    logic [15:0]  e_cnt;
  } vec_t;

  vec_t vt[11];

  function automatic logic [63:0] p4(int x0, int x1, int x2, int x3);
    return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
  endfunction

  function automatic logic [127:0] r4(int x0, int x1, int x2, int x3);
    return {x3, x2, x1, x0};
  endfunction

  function automatic vec_t mk(logic clr, logic md, logic iv, logic il,
                              logic ordy, logic [63:0] a, logic [63:0] b,
                              logic e_ir, logic e_ov, logic [127:0] e_res,
                              logic [15:0] e_cnt);
    vec_t v;
    v.clr = clr; v.md = md; v.iv = iv; v.il = il; v.ordy = ordy;
    v.a = a; v.b = b; v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_res = e_res; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(string tag, logic e_ir, logic e_ov,
                         logic [127:0] e_res, logic [15:0] e_cnt,
                         logic e_ovf);
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(e_ir));
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(e_ov));
    chk({tag, ".results"}, mac_results_flat, e_res);
    chk({tag, ".beat_count"}, 128'(beat_count), 128'(e_cnt));
    chk({tag, ".ovf"}, 128'(ovf), 128'(e_ovf));
  endtask

  task automatic drive(logic clr, logic md, logic iv, logic il, logic ordy,
                       logic [63:0] a, logic [63:0] b);
    acc_clr = clr; mode = md; in_valid = iv; in_last = il;
    out_ready = ordy; a_flat = a; b_flat = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(int x, int y);
    drive(0, 0, 1, 1, 0, p4(x, 0, 0, 0), p4(y, 0, 0, 0));
    tick();
  endtask

  task automatic handshake();
    drive(0, 0, 0, 0, 1, '0, '0);
    tick();
  endtask

  logic [127:0] zero_res;
  logic [127:0] sat_res;
  logic         sat_ovf;

  initial begin
    zero_res = '0;
`ifdef PE_SAT_EN
    sat_res = r4(2147483647, 0, 0, 0);
    sat_ovf = 1'b1;
`else
    sat_res = r4(0, 0, 0, 0);
    sat_ovf = 1'b0;
`endif

    vt[0]  = mk(0, 0, 1, 0, 0, p4(2, 2, 2, 2), p4(1, 2, 3, 4), 1, 0, zero_res, 0);
    vt[1]  = mk(0, 0, 1, 0, 0, p4(2, 2, 2, 2), p4(1, 2, 3, 4), 1, 0, zero_res, 0);
    vt[2]  = mk(0, 0, 1, 1, 0, p4(2, 2, 2, 2), p4(1, 2, 3, 4), 0, 1,
                r4(6, 12, 18, 24), 3);
    vt[3]  = mk(0, 0, 0, 0, 1, '0, '0, 1, 0, zero_res, 0);
    vt[4]  = mk(0, 1, 1, 1, 0, p4(1, 2, 3, 4), p4(5, 6, 7, 8), 0, 1,
                r4(70, 0, 0, 0), 1);
    vt[5]  = mk(0, 0, 0, 0, 1, '0, '0, 1, 0, zero_res, 0);
    vt[6]  = mk(0, 1, 1, 0, 0, p4(1, 1, 1, 1), p4(1, 1, 1, 1), 1, 0, zero_res, 0);
    vt[7]  = mk(0, 0, 1, 1, 0, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 0, 1,
                r4(14, 0, 0, 0), 2);
    vt[8]  = mk(0, 0, 0, 0, 1, '0, '0, 1, 0, zero_res, 0);
    vt[9]  = mk(0, 0, 1, 1, 0, p4(-3, 5, -7, 100), p4(4, -6, -8, 100), 0, 1,
                r4(-12, -30, 56, 10000), 1);
    vt[10] = mk(0, 0, 0, 0, 1, '0, '0, 1, 0, zero_res, 0);

    // Reset with junk beats offered
    rst = 1'b0;
    drive(0, 0, 1, 1, 1, p4(9, 9, 9, 9), p4(9, 9, 9, 9));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("init_rst%0d", i), 0, 0, zero_res, 0, 0);
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, '0, '0);
    #1;
    chk_out("init_release", 1, 0, zero_res, 0, 0);

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].clr, vt[i].md, vt[i].iv, vt[i].il, vt[i].ordy,
            vt[i].a, vt[i].b);
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].e_ir, vt[i].e_ov,
              vt[i].e_res, vt[i].e_cnt, 1'b0);
    end

    // Reset mid-group
    drive(0, 0, 1, 0, 0, p4(7, 0, 0, 0), p4(7, 0, 0, 0));
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 1, 1, p4(7, 0, 0, 0), p4(7, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("midrst%0d", i), 0, 0, zero_res, 0, 0);
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, '0, '0);
    #1;
    chk_out("midrst_release", 1, 0, zero_res, 0, 0);
    one_beat(3, 3);
    chk_out("midrst_after", 0, 1, r4(9, 0, 0, 0), 1, 0);
    handshake();

    // Reset while in DONE
    one_beat(4, 4);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, '0, '0);
    tick();
    chk_out("donerst", 0, 0, zero_res, 0, 0);
    rst = 1'b1;
    one_beat(3, 3);
    chk_out("donerst_after", 0, 1, r4(9, 0, 0, 0), 1, 0);
    handshake();

    // Back-pressure in DONE
    one_beat(5, 5);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0, p4(11, 11, 11, 11), p4(11, 11, 11, 11));
      tick();
      chk_out($sformatf("stall%0d", i), 0, 1, r4(25, 0, 0, 0), 1, 0);
    end
    handshake();
    chk_out("stall_release", 1, 0, zero_res, 0, 0);

    // Abort on beat 2
    drive(0, 0, 1, 0, 0, p4(7, 0, 0, 0), p4(7, 0, 0, 0));
    tick();
    drive(1, 0, 1, 0, 0, p4(7, 0, 0, 0), p4(7, 0, 0, 0));
    tick();
    chk_out("clr_beat", 1, 0, zero_res, 0, 0);
    one_beat(3, 3);
    chk_out("clr_beat_after", 0, 1, r4(9, 0, 0, 0), 1, 0);
    handshake();

    // Abort in DONE, concurrent with a handshake
    one_beat(4, 4);
    drive(1, 0, 0, 0, 1, '0, '0);
    tick();
    chk_out("clr_done", 1, 0, zero_res, 0, 0);
    one_beat(3, 3);
    chk_out("clr_done_after", 0, 1, r4(9, 0, 0, 0), 1, 0);
    handshake();

    // Accumulator reaches 2^32
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i == 3), 0, p4(-32768, 0, 0, 0), p4(-32768, 0, 0, 0));
      tick();
    end
    chk_out("sat", 0, 1, sat_res, 4, sat_ovf);
    handshake();

    // 65536 beats saturate the 16-bit counter
    for (int i = 0; i < 65535; i++) begin
      drive(0, 0, 1, 0, 0, '0, '0);
      tick();
    end
    drive(0, 0, 1, 1, 0, '0, '0);
    tick();
    chk_out("cnt_sat", 0, 1, zero_res, 16'hFFFF, 0);
    handshake();
    chk_out("cnt_sat_release", 1, 0, zero_res, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/processing_element_v3.md
PROCESSING_ELEMENT_V3 -- requirements
Module: processing_element_v3

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed operand width per lane.
REQ-002 Parameter NUM_MACS, default 4: number of MAC lanes.
REQ-003 Parameter GUARD_BITS, default 8: extra accumulator headroom bits; internal ACC_WIDTH = 2*DATA_WIDTH+GUARD_BITS.
REQ-004 Parameter CNT_WIDTH, default 16: beat counter width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 acc_clr  input  1  synchronous abort: discard the current group, zero the accumulators.
REQ-008 mode  input  1  0 = lane-wise dot product, 1 = cross-lane reduction into lane 0.
REQ-009 in_valid  input  1  operand beat valid.
REQ-010 in_ready  output  1  block can accept a beat.
REQ-011 in_last  input  1  beat is final of the group.
REQ-012 a_flat, b_flat  input  NUM_MACS*DATA_WIDTH each  signed operands; lane i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-013 out_valid  output  1  results valid.
REQ-014 out_ready  input  1  consumer accepts results.
REQ-015 mac_results_flat  output  NUM_MACS*2*DATA_WIDTH  signed per-lane results, same lane packing, 2*DATA_WIDTH bits per lane.
REQ-016 beat_count  output  CNT_WIDTH  beats accepted in the delivered group.
REQ-017 ovf  output  1  saturation occurred in the delivered group.

Function
REQ-018 FSM states: IDLE, ACC, DONE; in_ready = 1 in IDLE/ACC, 0 in DONE; out_valid = 1 only in DONE.
REQ-019 Beat accepted when in_valid && in_ready; the products are added to the accumulators in that cycle's edge.
REQ-020 IDLE->ACC on accept without in_last; IDLE->DONE or ACC->DONE on accept with in_last; DONE->IDLE on out_valid && out_ready.
REQ-021 Latency: out_valid asserts on the cycle after the in_last beat is accepted.
REQ-022 mode is sampled on the first beat of a group (the beat accepted in IDLE) and held until the group is delivered or aborted.
REQ-023 Lane-wise: acc[i] += a[i]*b[i]; products are full 2*DATA_WIDTH signed and are sign-extended to ACC_WIDTH.
REQ-024 Reduction: acc[0] += sum over all lanes of a[i]*b[i], computed at ACC_WIDTH; acc[1..NUM_MACS-1] stay 0.
REQ-025 In DONE, mac_results_flat, beat_count and ovf are stable until the handshake; accumulators, counter and ovf clear on the DONE->IDLE transition.
REQ-026 beat_count increments per accepted beat and saturates at 2^CNT_WIDTH-1 (no wrap).
REQ-027 acc_clr asserted: next state is IDLE, and accumulators, beat_count and ovf are zeroed; this takes priority over a simultaneous accept or output handshake; in DONE, results are dropped.
REQ-028 Outputs mac_results_flat, beat_count and ovf read 0 outside DONE.
REQ-029 A single-beat group (in_last on the first beat) is legal and delivers one product set.

Reset
REQ-030 While rst = 0 at a clock edge: state becomes IDLE; all accumulators, beat_count and ovf are set to 0; in_ready, out_valid and mac_results_flat are 0.
REQ-031 Reset mid-group or in DONE discards all data with no output handshake; rst has priority over acc_clr and over both handshakes.
REQ-032 in_ready asserts on the first cycle after rst returns to 1.

Configuration
REQ-033 Macro PE_SAT_EN defined: each lane result saturates from ACC_WIDTH to the signed 2*DATA_WIDTH range; ovf is set if any lane clipped (evaluated when entering DONE).
REQ-034 PE_SAT_EN undefined: each lane result is the low 2*DATA_WIDTH bits of its accumulator (two's-complement wrap); ovf is tied to 0; no saturation logic is present.

Verification
REQ-035 Hold rst=0 for 3 cycles, mid-group -> in_ready=0 and out_valid=0 during reset; all outputs 0; in_ready=1 on the first cycle after release.
REQ-036 mode=0; 3 beats with a = {2,2,2,2} and b = {1,2,3,4} (lane0 first), in_last on beat 3 -> one cycle later out_valid=1, lanes = {6,12,18,24}, beat_count=3.
REQ-037 mode=1; one beat a = {1,2,3,4}, b = {5,6,7,8}, in_last=1 -> lane0=70, lanes 1-3 = 0, beat_count=1.
REQ-038 out_ready=0 for 5 cycles in DONE -> out_valid and results are held constant, in_ready=0, and in_valid is ignored; after the handshake, IDLE with in_ready=1.
REQ-039 mode=0; 4 beats with a = b = -32768 on lane 0 -> accumulator = 2^32; with PE_SAT_EN: lane0 = 2147483647, ovf=1; without: lane0 = 0, ovf=0.
REQ-040 acc_clr pulsed on the same cycle as beat 2 of a group (also checked in DONE) -> beat not added, IDLE next cycle; a following 1-beat group {3}*{3} gives lane0 = 9 and beat_count = 1.
